// File: rtl/uparc_lsu_pkg.sv
// uparc_lsu_pkg
// Shared constants for the load/store stage: register/address widths,
// LSU op encodings, bus command encodings, FSM state type and a few
// op-classification helpers used by the top and the align sub-module.
package uparc_lsu_pkg;

  localparam int UPARC_REG_WIDTH    = 32;
  localparam int UPARC_ADDR_WIDTH   = 32;
  localparam int UPARC_LSUOP_WIDTH  = 4;
  localparam int UPARC_BUSCMD_WIDTH = 2;

  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_NONE = 4'd0;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_LB   = 4'd1;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_LBU  = 4'd2;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_LH   = 4'd3;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_LHU  = 4'd4;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_LW   = 4'd5;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_SB   = 4'd6;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_SH   = 4'd7;
  localparam logic [UPARC_LSUOP_WIDTH-1:0] UPARC_LSUOP_SW   = 4'd8;

  localparam logic [UPARC_BUSCMD_WIDTH-1:0] UPARC_BUSCMD_IDLE  = 2'd0;
  localparam logic [UPARC_BUSCMD_WIDTH-1:0] UPARC_BUSCMD_READ  = 2'd1;
  localparam logic [UPARC_BUSCMD_WIDTH-1:0] UPARC_BUSCMD_WRITE = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } lsu_state_t;

  function automatic logic lsu_is_load(input logic [UPARC_LSUOP_WIDTH-1:0] op);
    return (op == UPARC_LSUOP_LB) || (op == UPARC_LSUOP_LBU) ||
           (op == UPARC_LSUOP_LH) || (op == UPARC_LSUOP_LHU) ||
           (op == UPARC_LSUOP_LW);
  endfunction

  function automatic logic lsu_is_store(input logic [UPARC_LSUOP_WIDTH-1:0] op);
    return (op == UPARC_LSUOP_SB) || (op == UPARC_LSUOP_SH) ||
           (op == UPARC_LSUOP_SW);
  endfunction

  // Bytes never fault; halves need addr[0]==0; words need addr[1:0]==0.
  function automatic logic lsu_misaligned(input logic [UPARC_LSUOP_WIDTH-1:0] op,
                                          input logic [1:0] lo);
    case (op)
      UPARC_LSUOP_LH, UPARC_LSUOP_LHU, UPARC_LSUOP_SH: return lo[0];
      UPARC_LSUOP_LW, UPARC_LSUOP_SW:                  return |lo;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uparc_lsu_align.sv
// uparc_lsu_align
// Purely combinational lane logic for little-endian byte/half/word access.
//   Store side: st_op, st_lane, st_data -> st_be (byte enables, also used for
//               loads), st_rep (store data replicated across lanes).
//   Load side:  ld_op, ld_lane, ld_data -> ld_val (selected lane, sign- or
//               zero-extended; full word for LW and any non-sub-word op).
module uparc_lsu_align
  import uparc_lsu_pkg::*;
(
  input  logic [UPARC_LSUOP_WIDTH-1:0] st_op,
  input  logic [1:0]                   st_lane,
  input  logic [UPARC_REG_WIDTH-1:0]   st_data,
  output logic [3:0]                   st_be,
  output logic [UPARC_REG_WIDTH-1:0]   st_rep,
  input  logic [UPARC_LSUOP_WIDTH-1:0] ld_op,
  input  logic [1:0]                   ld_lane,
  input  logic [UPARC_REG_WIDTH-1:0]   ld_data,
  output logic [UPARC_REG_WIDTH-1:0]   ld_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_be  = 4'b0000;
    st_rep = st_data;
    case (st_op)
      UPARC_LSUOP_LB, UPARC_LSUOP_LBU, UPARC_LSUOP_SB: begin
        st_be  = 4'b0001 << st_lane;
        st_rep = {4{st_data[7:0]}};
      end
      UPARC_LSUOP_LH, UPARC_LSUOP_LHU, UPARC_LSUOP_SH: begin
        st_be  = st_lane[1] ? 4'b1100 : 4'b0011;
        st_rep = {2{st_data[15:0]}};
      end
      UPARC_LSUOP_LW, UPARC_LSUOP_SW: begin
        st_be  = 4'b1111;
      end
      default: begin
        st_be  = 4'b0000;
      end
    endcase
  end

  always_comb begin
    byte_sel = ld_data[7:0];
    case (ld_lane)
      2'd0: byte_sel = ld_data[7:0];
      2'd1: byte_sel = ld_data[15:8];
      2'd2: byte_sel = ld_data[23:16];
      2'd3: byte_sel = ld_data[31:24];
      default: byte_sel = ld_data[7:0];
    endcase
    half_sel = ld_lane[1] ? ld_data[31:16] : ld_data[15:0];

    ld_val = ld_data;
    case (ld_op)
      UPARC_LSUOP_LB:  ld_val = {{24{byte_sel[7]}}, byte_sel};
      UPARC_LSUOP_LBU: ld_val = {24'd0, byte_sel};
      UPARC_LSUOP_LH:  ld_val = {{16{half_sel[15]}}, half_sel};
      UPARC_LSUOP_LHU: ld_val = {16'd0, half_sel};
      default:         ld_val = ld_data;
    endcase
  end

endmodule

// File: rtl/uparc_lsu.sv
// uparc_lsu
// Load/store pipeline stage. Takes the ALU result as an effective address
// (memory ops) or pass-through value (NONE), runs one single-beat bus
// transaction per aligned memory op and produces a one-cycle writeback
// strobe carrying either a result or an exception.
//   Upstream:  i_valid, i_ready, i_op, i_addr, i_wdata, i_rd
//   Bus:       b_cmd, b_addr, b_wdata, b_be (registered, held during BUS);
//              b_rdata, b_rdy, b_err (b_err only meaningful with b_rdy)
//   Writeback: o_valid, o_rd, o_result, o_wb_en, o_exc_adel, o_exc_ades,
//              o_exc_bus, o_badvaddr
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accepting ops; NONE and misaligned ops complete from here
// BUS   | bus transaction outstanding; bus outputs frozen until b_rdy
module uparc_lsu
  import uparc_lsu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic [UPARC_LSUOP_WIDTH-1:0]  i_op,
  input  logic [UPARC_ADDR_WIDTH-1:0]   i_addr,
  input  logic [UPARC_REG_WIDTH-1:0]    i_wdata,
  input  logic [4:0]                    i_rd,
  output logic [UPARC_BUSCMD_WIDTH-1:0] b_cmd,
  output logic [UPARC_ADDR_WIDTH-1:0]   b_addr,
  output logic [UPARC_REG_WIDTH-1:0]    b_wdata,
  output logic [3:0]                    b_be,
  input  logic [UPARC_REG_WIDTH-1:0]    b_rdata,
  input  logic                          b_rdy,
  input  logic                          b_err,
  output logic                          o_valid,
  output logic [4:0]                    o_rd,
  output logic [UPARC_REG_WIDTH-1:0]    o_result,
  output logic                          o_wb_en,
  output logic                          o_exc_adel,
  output logic                          o_exc_ades,
  output logic                          o_exc_bus,
  output logic [UPARC_ADDR_WIDTH-1:0]   o_badvaddr
);

  lsu_state_t                   state_q, state_nxt;
  logic [UPARC_LSUOP_WIDTH-1:0] op_q;
  logic [4:0]                   rd_q;
  logic [UPARC_ADDR_WIDTH-1:0]  vaddr_q;

  logic                         in_load, in_store, in_misal;
  logic                         accept, start_bus, done;
  logic [3:0]                   be_c;
  logic [UPARC_REG_WIDTH-1:0]   rep_c;
  logic [UPARC_REG_WIDTH-1:0]   ld_val;

  assign in_load  = lsu_is_load(i_op);
  assign in_store = lsu_is_store(i_op);
  assign in_misal = lsu_misaligned(i_op, i_addr[1:0]);
  assign i_ready  = (state_q == ST_IDLE);

  // Store side is driven from the incoming op; load side from the op held
  // for the outstanding transaction.
  uparc_lsu_align u_align (
    .st_op   (i_op),
    .st_lane (i_addr[1:0]),
    .st_data (i_wdata),
    .st_be   (be_c),
    .st_rep  (rep_c),
    .ld_op   (op_q),
    .ld_lane (vaddr_q[1:0]),
    .ld_data (b_rdata),
    .ld_val  (ld_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    accept    = 1'b0;
    start_bus = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          accept = 1'b1;
          if ((in_load || in_store) && !in_misal) begin
            start_bus = 1'b1;
            state_nxt = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (b_rdy) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_cmd   <= UPARC_BUSCMD_IDLE;
      b_addr  <= '0;
      b_wdata <= '0;
      b_be    <= '0;
      op_q    <= UPARC_LSUOP_NONE;
      rd_q    <= '0;
      vaddr_q <= '0;
    end else if (start_bus) begin
      b_cmd   <= in_store ? UPARC_BUSCMD_WRITE : UPARC_BUSCMD_READ;
      b_addr  <= {i_addr[UPARC_ADDR_WIDTH-1:2], 2'b00};
      b_wdata <= in_store ? rep_c : '0;
      b_be    <= be_c;
      op_q    <= i_op;
      rd_q    <= i_rd;
      vaddr_q <= i_addr;
    end else if (done) begin
      b_cmd   <= UPARC_BUSCMD_IDLE;
    end
  end

  // Writeback outputs are pulses: everything falls back to zero unless a
  // completion is being reported this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_rd       <= '0;
      o_result   <= '0;
      o_wb_en    <= 1'b0;
      o_exc_adel <= 1'b0;
      o_exc_ades <= 1'b0;
      o_exc_bus  <= 1'b0;
      o_badvaddr <= '0;
    end else begin
      o_valid    <= 1'b0;
      o_rd       <= '0;
      o_result   <= '0;
      o_wb_en    <= 1'b0;
      o_exc_adel <= 1'b0;
      o_exc_ades <= 1'b0;
      o_exc_bus  <= 1'b0;
      o_badvaddr <= '0;
      if (accept && !start_bus) begin
        o_valid <= 1'b1;
        o_rd    <= i_rd;
        if (in_misal) begin
          o_exc_adel <= in_load;
          o_exc_ades <= in_store;
          o_badvaddr <= i_addr;
        end else begin
          o_result <= i_addr;
          o_wb_en  <= (i_rd != 5'd0);
        end
      end else if (done) begin
        o_valid <= 1'b1;
        o_rd    <= rd_q;
        if (b_err) begin
          o_exc_bus  <= 1'b1;
          o_badvaddr <= vaddr_q;
        end else if (lsu_is_load(op_q)) begin
          o_result <= ld_val;
          o_wb_en  <= (rd_q != 5'd0);
        end
      end
    end
  end

endmodule

// File: tb/tb_uparc_lsu.sv
// tb_uparc_lsu
// Directed cases plus randomized op sequences against a behavioural model
// of the load/store stage (byte-lane arithmetic, no reuse of RTL structure).
module tb_uparc_lsu;
  import uparc_lsu_pkg::*;

  logic        clk, rst;
  logic        i_valid, i_ready;
  logic [3:0]  i_op;
  logic [31:0] i_addr, i_wdata;
  logic [4:0]  i_rd;
  logic [1:0]  b_cmd;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic        b_rdy, b_err;
  logic        o_valid, o_wb_en, o_exc_adel, o_exc_ades, o_exc_bus;
  logic [4:0]  o_rd;
  logic [31:0] o_result, o_badvaddr;

  int n_checks = 0;
  int n_errors = 0;

  uparc_lsu dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rd(i_rd),
    .b_cmd(b_cmd), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .b_rdata(b_rdata), .b_rdy(b_rdy), .b_err(b_err),
    .o_valid(o_valid), .o_rd(o_rd), .o_result(o_result), .o_wb_en(o_wb_en),
    .o_exc_adel(o_exc_adel), .o_exc_ades(o_exc_ades), .o_exc_bus(o_exc_bus),
    .o_badvaddr(o_badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      UPARC_LSUOP_LB, UPARC_LSUOP_LBU, UPARC_LSUOP_SB: return 1;
      UPARC_LSUOP_LH, UPARC_LSUOP_LHU, UPARC_LSUOP_SH: return 2;
      UPARC_LSUOP_LW, UPARC_LSUOP_SW:                  return 4;
      default:                                         return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [3:0] op);
    return (op == UPARC_LSUOP_SB) || (op == UPARC_LSUOP_SH) || (op == UPARC_LSUOP_SW);
  endfunction

  function automatic bit op_signed(input logic [3:0] op);
    return (op == UPARC_LSUOP_LB) || (op == UPARC_LSUOP_LH);
  endfunction

  function automatic bit misal(input logic [3:0] op, input logic [31:0] a);
    int sz = op_size(op);
    return (sz != 0) && ((a % sz) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
    int s = int'(a % 4);
    int sz = op_size(op);
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (i >= s && i < s + sz) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_rep(input logic [3:0] op, input logic [31:0] wd);
    int sz = op_size(op);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz = op_size(op);
    logic [31:0] v = rd >> (8 * (a % 4));
    if (sz == 1) begin
      v = v & 32'hFF;
      if (op_signed(op) && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (op_signed(op) && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // One complete op: offer, accept, optional bus phase, writeback check.
  // Called at posedge+1; returns at posedge+1 of the o_valid cycle.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input int waits, input bit err, input logic [31:0] rdata);
    bit mem = (op_size(op) != 0) && !misal(op, addr);
    i_valid = 1'b1; i_op = op; i_addr = addr; i_wdata = wdata; i_rd = rd;
    b_rdy = 1'($urandom_range(0, 1));  // ignored while idle
    b_err = 1'($urandom_range(0, 1));
    b_rdata = $urandom;
    chk("ready_at_offer", i_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0; b_rdy = 1'b0; b_err = 1'b0;
    if (!mem) begin
      chk("valid_nomem", o_valid, 1);
      chk("cmd_nomem", b_cmd, UPARC_BUSCMD_IDLE);
      chk("ready_nomem", i_ready, 1);
      chk("rd_nomem", o_rd, rd);
      if (op_size(op) == 0) begin
        chk("result_none", o_result, addr);
        chk("wb_none", o_wb_en, rd != 0);
        chk("exc_none", {o_exc_adel, o_exc_ades, o_exc_bus}, 3'b000);
      end else begin
        chk("wb_misal", o_wb_en, 0);
        chk("exc_misal", {o_exc_adel, o_exc_ades, o_exc_bus},
            op_store(op) ? 3'b010 : 3'b100);
        chk("badvaddr_misal", o_badvaddr, addr);
      end
    end else begin
      for (int w = 0; w <= waits; w++) begin
        chk("cmd_bus", b_cmd, op_store(op) ? UPARC_BUSCMD_WRITE : UPARC_BUSCMD_READ);
        chk("addr_bus", b_addr, addr & 32'hFFFF_FFFC);
        chk("be_bus", b_be, exp_be(op, addr));
        if (op_store(op)) chk("wdata_bus", b_wdata, exp_rep(op, wdata));
        chk("ready_bus", i_ready, 0);
        chk("valid_bus", o_valid, 0);
        if (w == waits) begin
          b_rdy = 1'b1; b_err = err; b_rdata = rdata;
        end else begin
          b_rdata = $urandom;
        end
        @(posedge clk); #1;
      end
      b_rdy = 1'b0; b_err = 1'b0;
      chk("valid_done", o_valid, 1);
      chk("ready_done", i_ready, 1);
      chk("cmd_done", b_cmd, UPARC_BUSCMD_IDLE);
      chk("rd_done", o_rd, rd);
      chk("exc_done", {o_exc_adel, o_exc_ades, o_exc_bus}, err ? 3'b001 : 3'b000);
      chk("wb_done", o_wb_en, !err && !op_store(op) && rd != 0);
      if (err) chk("badvaddr_bus", o_badvaddr, addr);
      else if (op_store(op)) chk("result_store", o_result, 0);
      else chk("result_load", o_result, exp_load(op, addr, rdata));
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    rst = 1'b1; i_valid = 1'b0; i_op = '0; i_addr = '0; i_wdata = '0; i_rd = '0;
    b_rdata = '0; b_rdy = 1'b0; b_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd", b_cmd, UPARC_BUSCMD_IDLE);
    chk("rst_ready", i_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op(UPARC_LSUOP_NONE, 32'h1234_5678, 32'h0, 5'd3, 0, 0, 32'h0);
    do_op(UPARC_LSUOP_NONE, 32'h1234_5678, 32'h0, 5'd0, 0, 0, 32'h0);
    do_op(UPARC_LSUOP_LB,   32'h1000_0003, 32'h0, 5'd4, 0, 0, 32'h80FF_0000);
    do_op(UPARC_LSUOP_LBU,  32'h1000_0003, 32'h0, 5'd4, 0, 0, 32'h80FF_0000);
    do_op(UPARC_LSUOP_SH,   32'h2000_0002, 32'hAAAA_BEEF, 5'd5, 3, 0, 32'h0);
    do_op(UPARC_LSUOP_LW,   32'h0000_0006, 32'h0, 5'd6, 0, 0, 32'h0);
    do_op(UPARC_LSUOP_SW,   32'h0000_0001, 32'h0, 5'd6, 0, 0, 32'h0);
    do_op(UPARC_LSUOP_LW,   32'h0000_0040, 32'h0, 5'd7, 1, 1, 32'hDEAD_BEEF);
    do_op(UPARC_LSUOP_LH,   32'h0000_0102, 32'h0, 5'd8, 0, 0, 32'h8001_7FFF);
    do_op(UPARC_LSUOP_LHU,  32'h0000_0102, 32'h0, 5'd8, 2, 0, 32'h8001_7FFF);

    // LW with a NONE offered during BUS: NONE taken in the o_valid cycle
    i_valid = 1'b1; i_op = UPARC_LSUOP_LW; i_addr = 32'h0000_0100; i_rd = 5'd9;
    @(posedge clk); #1;
    i_op = UPARC_LSUOP_NONE; i_addr = 32'h0000_CAFE; i_rd = 5'd7;
    chk("b2b_ready_bus", i_ready, 0);
    b_rdy = 1'b1; b_rdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    b_rdy = 1'b0;
    chk("b2b_lw_valid", o_valid, 1);
    chk("b2b_lw_result", o_result, 32'h1357_9BDF);
    chk("b2b_lw_rd", o_rd, 5'd9);
    chk("b2b_ready", i_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("b2b_none_valid", o_valid, 1);
    chk("b2b_none_result", o_result, 32'h0000_CAFE);
    chk("b2b_none_rd", o_rd, 5'd7);
    @(posedge clk); #1;
    chk("b2b_idle_valid", o_valid, 0);

    // Reset mid-BUS
    i_valid = 1'b1; i_op = UPARC_LSUOP_LW; i_addr = 32'h0000_0200; i_rd = 5'd2;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("mid_cmd_before", b_cmd, UPARC_BUSCMD_READ);
    #1 rst = 1'b1;
    #1;
    chk("mid_cmd_async", b_cmd, UPARC_BUSCMD_IDLE);
    chk("mid_ready_async", i_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; b_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mid_no_valid", o_valid, 0);
      chk("mid_cmd_idle", b_cmd, UPARC_BUSCMD_IDLE);
    end
    b_rdy = 1'b0;

    // Randomized ops
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom_range(0, 8));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && op_size(op) != 0)
        a = a & ~(32'(op_size(op)) - 32'd1);
      do_op(op, a, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("gap_valid", o_valid, 0);
        chk("gap_wb", o_wb_en, 0);
        chk("gap_exc", {o_exc_adel, o_exc_ades, o_exc_bus}, 3'b000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
